// File: rtl/button_debounce_fsm.sv
// Button debouncer: two-flop synchroniser plus a 4-state qualification FSM paced by timer ticks.
// Optional DEBOUNCE_LONG_PRESS_EN adds a long_press strobe after LONG_TICKS ticks of stable high.
module button_debounce_fsm #(
   parameter int STABLE_TICKS = 4,
   parameter int LONG_TICKS   = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   input  logic tick,
   output logic timer_en,
   output logic btn_level,
   output logic rise,
   output logic fall
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,
   output logic long_press
`endif
);

   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] LAST_TICK = CW'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sync_q;
   logic            btn_s;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   assign btn_s = sync_q[1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b00;
         state_q <= S_LOW;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (btn_s) begin
               state_d = S_WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         S_WAIT_HIGH: begin
            // A bounce wins over a tick arriving in the same cycle.
            if (!btn_s) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == LAST_TICK) begin
                  state_d = S_HIGH;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_HIGH: begin
            if (!btn_s) begin
               state_d = S_WAIT_LOW;
               cnt_d   = '0;
            end
         end
         S_WAIT_LOW: begin
            if (btn_s) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == LAST_TICK) begin
                  state_d = S_LOW;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign btn_level = (state_q == S_HIGH) || (state_q == S_WAIT_LOW);
   assign rise      = rise_q;
   assign fall      = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_TICKS + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);

   logic [LW-1:0] long_cnt_q, long_cnt_d;
   logic          long_q, long_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         long_cnt_q <= long_cnt_d;
         long_q     <= long_d;
      end
   end

   // Frozen in S_WAIT_LOW, saturates at LONG_MAX so the strobe never repeats.
   always_comb begin
      long_cnt_d = long_cnt_q;
      long_d     = 1'b0;
      if (state_d == S_LOW) begin
         long_cnt_d = '0;
      end else if ((state_q == S_HIGH) && tick && (long_cnt_q != LONG_MAX)) begin
         long_cnt_d = long_cnt_q + 1'b1;
         long_d     = (long_cnt_d == LONG_MAX);
      end
   end

   assign long_press = long_q;
   assign timer_en   = (state_q != S_LOW);
`else
   assign timer_en   = (state_q == S_WAIT_HIGH) || (state_q == S_WAIT_LOW);
`endif

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Scoreboard bench for button_debounce_fsm: a level/qualification model predicts every cycle,
// a monitor compares; directed scenarios cover press, release, bounce, reset and long press.
module tb_button_debounce_fsm;

   localparam int STABLE_TICKS = 4;
   localparam int LONG_TICKS   = 8;
   localparam int TICK_PERIOD  = 5;
`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam bit LP = 1'b1;
`else
   localparam bit LP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, btn_raw, tick;
   logic timer_en, btn_level, rise, fall;
   logic lp_out;

   always #5 clk = ~clk;

`ifdef DEBOUNCE_LONG_PRESS_EN
   button_debounce_fsm #(.STABLE_TICKS(STABLE_TICKS), .LONG_TICKS(LONG_TICKS)) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .tick(tick), .timer_en(timer_en),
      .btn_level(btn_level), .rise(rise), .fall(fall), .long_press(lp_out));
`else
   button_debounce_fsm #(.STABLE_TICKS(STABLE_TICKS), .LONG_TICKS(LONG_TICKS)) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .tick(tick), .timer_en(timer_en),
      .btn_level(btn_level), .rise(rise), .fall(fall));
   assign lp_out = 1'b0;
`endif

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic ten;
      logic lp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, failures = 0;
   int   rise_seen = 0, fall_seen = 0, lp_seen = 0;
   int   phase = 0;

   // Reference model: accepted level, whether a change is being qualified, ticks seen so far.
   bit m_s1, m_s2, m_level, m_wait, m_rise, m_fall, m_lpp;
   int m_n, m_lp;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_edge(input bit raw, input bit tk, input bit rst);
      bit s, was_high;
      m_rise = 0; m_fall = 0; m_lpp = 0;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_wait = 0; m_n = 0; m_lp = 0;
         return;
      end
      s        = m_s2;
      was_high = m_level && !m_wait;
      m_s2     = m_s1;
      m_s1     = raw;
      if (LP && was_high && tk && m_lp < LONG_TICKS) begin
         m_lp++;
         if (m_lp == LONG_TICKS) m_lpp = 1;
      end
      if (!m_wait) begin
         if (s != m_level) begin m_wait = 1; m_n = 0; end
      end else if (s == m_level) begin
         m_wait = 0;
      end else if (tk) begin
         m_n++;
         if (m_n == STABLE_TICKS) begin
            m_level = !m_level;
            m_wait  = 0;
            if (m_level) m_rise = 1;
            else begin m_fall = 1; m_lp = 0; end
         end
      end
   endtask

   // Called just after a falling edge: drives inputs for the next rising edge and queues the prediction.
   task automatic drive(input bit raw, input bit tk, input bit rst = 1'b0);
      exp_t e;
      btn_raw = raw;
      tick    = tk;
      reset   = rst;
      if (rst) begin
         #1;
         check("async_reset_outputs", {btn_level, rise, fall, timer_en, lp_out}, 0);
      end
      model_edge(raw, tk, rst);
      e.level = m_level;
      e.rise  = m_rise;
      e.fall  = m_fall;
      e.ten   = m_wait || (LP && m_level);
      e.lp    = m_lpp;
      exp_q.push_back(e);
   endtask

   function automatic bit next_tick();
      bit t = (phase % TICK_PERIOD) == 0;
      phase++;
      return t;
   endfunction

   task automatic hold(input bit raw, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         drive(raw, next_tick());
      end
   endtask

   // Steps raw to a new level until btn_level follows; n = ticks landing after WAIT entry (3 cycles).
   task automatic qualify(input bit raw, output int n);
      bit tk;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (btn_level == raw) return;
         tk = next_tick();
         if (tk && i >= 3) n++;
         drive(raw, tk);
      end
      n = -1;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) continue;
         e = exp_q.pop_front();
         check("btn_level", btn_level, e.level);
         check("rise", rise, e.rise);
         check("fall", fall, e.fall);
         check("timer_en", timer_en, e.ten);
         check("long_press", lp_out, e.lp);
         if (rise) rise_seen++;
         if (fall) fall_seen++;
         if (lp_out) lp_seen++;
      end
   end

   initial begin : stimulus
      int n, r0, f0, l0;
      bit raw;
      reset = 1'b1; btn_raw = 1'b0; tick = 1'b0;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_wait = 0; m_n = 0; m_lp = 0;
      @(negedge clk); drive(0, 0, 1);
      @(negedge clk); drive(0, 0, 1);
      hold(0, 10);

      // Clean press then release.
      r0 = rise_seen; f0 = fall_seen;
      qualify(1, n);
      check("press_ticks", n, STABLE_TICKS);
      hold(1, 20);
      check("press_one_rise", rise_seen - r0, 1);
      check("press_no_fall", fall_seen - f0, 0);
      qualify(0, n);
      check("release_ticks", n, STABLE_TICKS);
      hold(0, 5);
      check("release_one_fall", fall_seen - f0, 1);

      // Bounce abort after about two ticks, then a full restart.
      r0 = rise_seen;
      hold(1, 12);
      hold(0, 3);
      settle();
      check("bounce_back_to_low", {btn_level, timer_en}, 0);
      check("bounce_no_rise", rise_seen - r0, 0);
      qualify(1, n);
      check("restart_ticks", n, STABLE_TICKS);
      qualify(0, n);

      // Bounce arriving together with the qualifying tick.
      r0 = rise_seen;
      for (int i = 0; i < 3; i++) begin @(negedge clk); drive(1, 0); end
      for (int t = 0; t < 3; t++) begin
         @(negedge clk); drive(1, 1);
         for (int i = 0; i < 4; i++) begin @(negedge clk); drive(1, 0); end
      end
      @(negedge clk); drive(0, 0);
      @(negedge clk); drive(0, 0);
      @(negedge clk); drive(0, 1);
      settle();
      check("simul_bounce_low", {btn_level, timer_en}, 0);
      check("simul_bounce_no_rise", rise_seen - r0, 0);

      // Reset in S_WAIT_LOW with two ticks counted.
      qualify(1, n);
      for (int i = 0; i < 3; i++) begin @(negedge clk); drive(0, 0); end
      @(negedge clk); drive(0, 1);
      @(negedge clk); drive(0, 0);
      @(negedge clk); drive(0, 1);
      @(negedge clk); drive(0, 0);
      r0 = rise_seen; f0 = fall_seen;
      @(negedge clk); drive(0, 0, 1);
      hold(0, 40);
      check("post_reset_no_strobe", (rise_seen - r0) + (fall_seen - f0), 0);
      check("post_reset_level", btn_level, 0);

      // Button held high through reset release yields one rise.
      r0 = rise_seen; f0 = fall_seen;
      @(negedge clk); drive(1, 0, 1);
      qualify(1, n);
      check("held_reset_ticks", n, STABLE_TICKS);
      hold(1, 10);
      check("held_reset_rise", rise_seen - r0, 1);
      check("held_reset_no_fall", fall_seen - f0, 0);
      qualify(0, n);
      hold(0, 10);

`ifdef DEBOUNCE_LONG_PRESS_EN
      // Long press twice; the second run proves the counter cleared on release.
      for (int pass = 0; pass < 2; pass++) begin
         bit tk;
         l0 = lp_seen;
         qualify(1, n);
         n = 0;
         for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lp_out) break;
            tk = next_tick();
            if (tk) n++;
            drive(1, tk);
         end
         check("long_press_ticks", n, LONG_TICKS);
         hold(1, 12 * TICK_PERIOD);
         check("long_press_once", lp_seen - l0, 1);
         qualify(0, n);
         hold(0, 10);
      end
`else
      l0 = lp_seen;
      hold(1, 120);
      check("no_long_press", lp_seen - l0, 0);
      qualify(0, n);
`endif

      // Randomised bouncing, ticks and occasional resets against the model.
      raw = btn_raw;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) raw = !raw;
         drive(raw, $urandom_range(0, 2) == 0, $urandom_range(0, 399) == 0);
      end

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_debounce_fsm.md
# button_debounce_fsm

Debounce controller that sits directly downstream of the free-running tick timer in the button edge-detection path. It synchronises the raw button input and drives the timer's `enable` while a level change is being qualified. It consumes the timer's `done` pulse as `tick` and declares a new stable level after `STABLE_TICKS` consecutive ticks with no bounce. Its outputs are a clean level plus single-cycle rise/fall strobes for the rest of the design.

## Interface
- `STABLE_TICKS`, default 4: consecutive ticks of unchanged input needed to accept a new level; legal range ≥ 1.
- `LONG_TICKS`, default 64: ticks of continuous stable-high needed for `long_press`; only used with the macro.

Ports (name, direction, width, meaning):
- `clk`: input, 1, single clock for everything.
- `reset`: input, 1. Asynchronous, active-high; clears all state.
- `btn_raw`: input, 1, asynchronous bouncing button.
- `tick`: input, 1. One-cycle strobe from the timer's `done`; sampled only while `timer_en` = 1.
- `timer_en`: output, 1, drives the timer `enable`.
- `btn_level`: output, 1, debounced level.
- `rise`: output, 1, one-cycle strobe on accepted 0→1.
- `fall`: output, 1, one-cycle strobe on accepted 1→0.
- `long_press`: output, 1. One-cycle strobe; present only with the macro.

## Operation
- Synchroniser:
  - Two flops, both reset to 0. `btn_s` is the second flop.
  - All FSM decisions use `btn_s` only.
- FSM has 2-bit state: `S_LOW`, `S_WAIT_HIGH`, `S_HIGH`, `S_WAIT_LOW`. Reset state is `S_LOW`.
- Tick counter:
  - Width is `$clog2(STABLE_TICKS+1)`; resets to 0.
  - It is cleared on every entry to a WAIT state.
- `S_LOW`:
  - `btn_s` = 1 → `S_WAIT_HIGH`, counter = 0.
- `S_WAIT_HIGH`:
  - `btn_s` = 0 → `S_LOW`, counter cleared. Bounce has priority over a simultaneous `tick`.
  - Otherwise, `tick` with counter = `STABLE_TICKS`-1 → `S_HIGH` and assert `rise`.
  - Otherwise, `tick` → counter + 1.
- `S_HIGH`:
  - `btn_s` = 0 → `S_WAIT_LOW`, counter = 0.
- `S_WAIT_LOW`:
  - Mirror of `S_WAIT_HIGH` with polarity inverted.
  - Bounce returns to `S_HIGH`; completion goes to `S_LOW` and asserts `fall`.
- `timer_en` = 1 exactly in `S_WAIT_HIGH` and `S_WAIT_LOW`, plus `S_HIGH` when the macro is enabled.
- `btn_level` = 1 in `S_HIGH` and `S_WAIT_LOW`; `btn_level` = 0 in `S_LOW` and `S_WAIT_HIGH`.
- `rise` and `fall` are never high together, and never in consecutive cycles.
- `tick` is ignored when `timer_en` = 0.

## Timing
- Reset values: `btn_level`, `rise`, `fall`, `timer_en` and `long_press` are all 0. The synchroniser is 0 and the state is `S_LOW`.
- Reset asserted mid-qualification aborts immediately. No strobe is emitted on or after reset.
- `btn_raw` change to `btn_s`: 2 cycles.
- `btn_s` change to WAIT state and `timer_en` = 1: 1 cycle.
- `btn_level`, `rise` and `fall` are registered:
  - They change on the clock edge that samples the qualifying `tick`.
  - The strobe lasts exactly 1 cycle.
- The timer is not restarted, so the first tick may arrive early. The qualification window is between (`STABLE_TICKS`-1) and `STABLE_TICKS` full tick periods after entry.
- If `btn_raw` is held 1 through reset release, the block sees 0→1 and produces one `rise` after qualification. There is no `fall`.

## Configuration
- Macro: `DEBOUNCE_LONG_PRESS_EN`.
- Defined:
  - `long_press` port exists.
  - A `$clog2(LONG_TICKS+1)`-bit saturating counter increments on each `tick` in `S_HIGH`, starting from 0.
  - It pulses `long_press` for 1 cycle when it reaches `LONG_TICKS`, then holds with no repeat.
  - The counter is frozen in `S_WAIT_LOW`, resumes if the FSM bounces back to `S_HIGH`, and clears on entry to `S_LOW`.
- Undefined:
  - No port and no counter.
  - `timer_en` is low in `S_HIGH`.

## Test plan
1. Clean press: `STABLE_TICKS`=4, tick every 5 cycles; `btn_raw` steps 0→1 and holds. Required: `btn_level` rises on the 4th tick after `timer_en` rises; exactly one `rise`; no `fall`.
2. Bounce abort: `btn_raw` 1 for 2 ticks, then 0 for 3 cycles, then 1. Required: FSM returns to `S_LOW`, no strobe; qualification restarts with the counter at 0.
3. Release: from stable high, `btn_raw` → 0. Required: one `fall` after 4 ticks; `btn_level` = 0 in the same cycle.
4. Simultaneous bounce and tick: drive `btn_s` = 0 in the same cycle as the 4th `tick` in `S_WAIT_HIGH`. Required: state becomes `S_LOW`; no `rise`.
5. Reset mid-op: assert `reset` for 1 cycle during `S_WAIT_LOW` with counter = 2. Required: all outputs 0 immediately. Then, with `btn_raw` still 0, no strobes follow.
6. Long press (macro on, `LONG_TICKS`=8): hold high for 20 ticks. Required: exactly one `long_press`, 8 ticks after `rise`; counter cleared after release.
